// File: rtl/line_sum_v.sv
//----------------------------------------------------------------------------
// line_sum_v : multi-flux vertical two-tap saturating adder (A + B per column)
// Revision   : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module line_sum_v #(
  parameter int FLUX                 = 2,
  parameter int DATA_WIDTH           = 18,
  parameter int DATA_WIDTH_EXT_SIZE  = 7,
  parameter int DATA_WIDTH_REAL_SIZE = 7,
  parameter int TAG_WIDTH            = (FLUX > 1) ? $clog2(FLUX) : 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  // sum output
  output logic [DATA_WIDTH+TAG_WIDTH-1:0]           write_port_din,
  output logic                                      write_port_write,
  input  logic                                      write_port_full,
  // current-row samples
  input  logic [DATA_WIDTH+TAG_WIDTH-1:0]           read_port_A_dout,
  input  logic [FLUX-1:0]                           read_port_A_empty,
  output logic [FLUX-1:0]                           read_port_A_read,
  // previous-row samples
  input  logic [DATA_WIDTH+TAG_WIDTH-1:0]           read_port_B_dout,
  input  logic [FLUX-1:0]                           read_port_B_empty,
  output logic [FLUX-1:0]                           read_port_B_read,
  // rows per block
  input  logic [DATA_WIDTH_EXT_SIZE+TAG_WIDTH-1:0]  read_port_ext_size_dout,
  input  logic [FLUX-1:0]                           read_port_ext_size_empty,
  output logic [FLUX-1:0]                           read_port_ext_size_read,
  // columns per row
  input  logic [DATA_WIDTH_REAL_SIZE+TAG_WIDTH-1:0] read_port_real_size_dout,
  input  logic [FLUX-1:0]                           read_port_real_size_empty,
  output logic [FLUX-1:0]                           read_port_real_size_read
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WORK = 1'b1
  } state_t;

  state_t                          r_state [FLUX];
  logic [DATA_WIDTH_REAL_SIZE-1:0] r_cnt_h [FLUX];
  logic [DATA_WIDTH_REAL_SIZE-1:0] r_max_h [FLUX];
  logic [DATA_WIDTH_EXT_SIZE-1:0]  r_cnt_v [FLUX];
  logic [DATA_WIDTH_EXT_SIZE-1:0]  r_max_v [FLUX];

  logic [FLUX-1:0]      w_c1, w_c2, w_c3, w_fire;
  logic [TAG_WIDTH-1:0] w_tag;
  logic                 w_any;
  logic [FLUX-1:0]      w_onehot;
  logic                 w_sel_c1, w_sel_ab, w_sel_c3;

  logic [DATA_WIDTH-1:0]           w_a, w_b, w_sat;
  logic [DATA_WIDTH:0]             w_sum;
  logic [DATA_WIDTH_EXT_SIZE-1:0]  w_ext;
  logic [DATA_WIDTH_REAL_SIZE-1:0] w_real;

  // Tag fields on the inputs carry no information here; the flux comes from the vectors.
  logic w_unused_tags;
  assign w_unused_tags = ^{read_port_A_dout[DATA_WIDTH+TAG_WIDTH-1:DATA_WIDTH],
                           read_port_B_dout[DATA_WIDTH+TAG_WIDTH-1:DATA_WIDTH],
                           read_port_ext_size_dout[DATA_WIDTH_EXT_SIZE+TAG_WIDTH-1:DATA_WIDTH_EXT_SIZE],
                           read_port_real_size_dout[DATA_WIDTH_REAL_SIZE+TAG_WIDTH-1:DATA_WIDTH_REAL_SIZE]};

  generate
    for (genvar f = 0; f < FLUX; f++) begin : g_flux
      logic w_ab_ok;
      assign w_ab_ok   = !read_port_A_empty[f] && !read_port_B_empty[f];
      assign w_c1[f]   = (r_state[f] == ST_IDLE) && !read_port_ext_size_empty[f]
                         && !read_port_real_size_empty[f];
      assign w_c2[f]   = (r_state[f] == ST_WORK) && (r_cnt_v[f] == '0) && w_ab_ok;
      assign w_c3[f]   = (r_state[f] == ST_WORK) && (r_cnt_v[f] != '0) && w_ab_ok
                         && !write_port_full;
      assign w_fire[f] = w_c1[f] || w_c2[f] || w_c3[f];
    end
  endgenerate

  // Lowest index wins: scan downward so the last hit is the smallest f.
  always_comb begin
    w_tag = '0;
    w_any = 1'b0;
    for (int f = FLUX - 1; f >= 0; f--) begin
      if (w_fire[f]) begin
        w_tag = TAG_WIDTH'(f);
        w_any = 1'b1;
      end
    end
  end

  assign w_onehot = FLUX'(1) << w_tag;
  assign w_sel_c1 = !rst && w_any && w_c1[w_tag];
  assign w_sel_ab = !rst && w_any && (w_c2[w_tag] || w_c3[w_tag]);
  assign w_sel_c3 = !rst && w_any && w_c3[w_tag];

  assign w_a    = read_port_A_dout[DATA_WIDTH-1:0];
  assign w_b    = read_port_B_dout[DATA_WIDTH-1:0];
  assign w_ext  = read_port_ext_size_dout[DATA_WIDTH_EXT_SIZE-1:0];
  assign w_real = read_port_real_size_dout[DATA_WIDTH_REAL_SIZE-1:0];
  assign w_sum  = {w_a[DATA_WIDTH-1], w_a} + {w_b[DATA_WIDTH-1], w_b};

  // Overflow shows up as disagreement between the two top bits of the widened sum.
  always_comb begin
    w_sat = w_sum[DATA_WIDTH-1:0];
    if (w_sum[DATA_WIDTH] != w_sum[DATA_WIDTH-1]) begin
      w_sat = w_sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end

  assign read_port_A_read         = w_sel_ab ? w_onehot : '0;
  assign read_port_B_read         = w_sel_ab ? w_onehot : '0;
  assign read_port_ext_size_read  = w_sel_c1 ? w_onehot : '0;
  assign read_port_real_size_read = w_sel_c1 ? w_onehot : '0;
  assign write_port_write         = w_sel_c3;
  assign write_port_din           = w_sel_c3 ? {w_tag, w_sat} : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int f = 0; f < FLUX; f++) begin
        r_state[f] <= ST_IDLE;
        r_cnt_h[f] <= '0;
        r_max_h[f] <= '0;
        r_cnt_v[f] <= '0;
        r_max_v[f] <= '0;
      end
    end else begin
      for (int f = 0; f < FLUX; f++) begin
        if (w_any && (w_tag == TAG_WIDTH'(f))) begin
          if (w_c1[f]) begin
            r_max_h[f] <= w_real - DATA_WIDTH_REAL_SIZE'(1);
            r_max_v[f] <= w_ext - DATA_WIDTH_EXT_SIZE'(1);
            r_cnt_h[f] <= '0;
            r_cnt_v[f] <= '0;
            r_state[f] <= ((w_ext == '0) || (w_real == '0)) ? ST_IDLE : ST_WORK;
          end else if (r_cnt_h[f] < r_max_h[f]) begin
            r_cnt_h[f] <= r_cnt_h[f] + DATA_WIDTH_REAL_SIZE'(1);
          end else if (r_cnt_v[f] < r_max_v[f]) begin
            r_cnt_h[f] <= '0;
            r_cnt_v[f] <= r_cnt_v[f] + DATA_WIDTH_EXT_SIZE'(1);
          end else begin
            r_cnt_h[f] <= '0;
            r_cnt_v[f] <= '0;
            r_state[f] <= ST_IDLE;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_line_sum_v.sv
//----------------------------------------------------------------------------
// tb_line_sum_v : directed scoreboard bench for line_sum_v
// Revision      : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_line_sum_v;

  localparam int FLUX = 2;
  localparam int DW   = 18;
  localparam int TW   = 1;
  localparam int EW   = 7;
  localparam int RW   = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [DW+TW-1:0] din;
  logic             wr;
  logic             full;
  logic [DW+TW-1:0] a_dout, b_dout;
  logic [EW+TW-1:0] e_dout;
  logic [RW+TW-1:0] r_dout;
  logic [FLUX-1:0]  a_empty, b_empty, e_empty, r_empty;
  logic [FLUX-1:0]  a_read, b_read, e_read, r_read;

  logic [DW-1:0] a_head [FLUX];
  logic [DW-1:0] b_head [FLUX];
  logic [EW-1:0] e_head [FLUX];
  logic [RW-1:0] r_head [FLUX];

  // Upstream FIFOs present the head of whichever flux is being read.
  assign a_dout = {1'b0, a_read[1] ? a_head[1] : a_head[0]};
  assign b_dout = {1'b0, b_read[1] ? b_head[1] : b_head[0]};
  assign e_dout = {1'b0, e_read[1] ? e_head[1] : e_head[0]};
  assign r_dout = {1'b0, r_read[1] ? r_head[1] : r_head[0]};

  line_sum_v #(
    .FLUX(FLUX), .DATA_WIDTH(DW), .DATA_WIDTH_EXT_SIZE(EW), .DATA_WIDTH_REAL_SIZE(RW)
  ) dut (
    .clk(clk), .rst(rst),
    .write_port_din(din), .write_port_write(wr), .write_port_full(full),
    .read_port_A_dout(a_dout), .read_port_A_empty(a_empty), .read_port_A_read(a_read),
    .read_port_B_dout(b_dout), .read_port_B_empty(b_empty), .read_port_B_read(b_read),
    .read_port_ext_size_dout(e_dout), .read_port_ext_size_empty(e_empty),
    .read_port_ext_size_read(e_read),
    .read_port_real_size_dout(r_dout), .read_port_real_size_empty(r_empty),
    .read_port_real_size_read(r_read)
  );

  int qa [FLUX][$];
  int qb [FLUX][$];
  int qe [FLUX][$];
  int qr [FLUX][$];
  int qx [FLUX][$];

  int n_cmp  = 0;
  int n_fail = 0;
  int rd_a [FLUX];
  int rd_e [FLUX];
  int wr_cnt;
  int wr_tag1;

  function automatic int sat(input int a, input int b);
    int s;
    s = a + b;
    if (s > 131071) return 131071;
    if (s < -131072) return -131072;
    return s;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    for (int f = 0; f < FLUX; f++) begin
      a_empty[f] = (qa[f].size() == 0);
      b_empty[f] = (qb[f].size() == 0);
      e_empty[f] = (qe[f].size() == 0);
      r_empty[f] = (qr[f].size() == 0);
      a_head[f]  = (qa[f].size() != 0) ? DW'(qa[f][0]) : '0;
      b_head[f]  = (qb[f].size() != 0) ? DW'(qb[f][0]) : '0;
      e_head[f]  = (qe[f].size() != 0) ? EW'(qe[f][0]) : '0;
      r_head[f]  = (qr[f].size() != 0) ? RW'(qr[f][0]) : '0;
    end
  endtask

  task automatic push_size(input int f, input int e, input int r);
    qe[f].push_back(e);
    qr[f].push_back(r);
    refresh();
  endtask

  task automatic push_pair(input int f, input int a, input int b, input bit emit);
    qa[f].push_back(a);
    qb[f].push_back(b);
    if (emit) qx[f].push_back(sat(a, b));
    refresh();
  endtask

  task automatic push_block(input int f, input int e, input int r, input int a0, input int b0);
    push_size(f, e, r);
    for (int k = 0; k < e * r; k++) push_pair(f, a0 + k, b0 + k, k >= r);
  endtask

  // One clock: sample at the falling edge, retire pops/writes, refresh after the rise.
  task automatic cycle();
    int t, e, d;
    @(negedge clk);
    if (rst) begin
      chk("rst_read", int'({a_read, b_read, e_read, r_read}), 0);
      chk("rst_write", int'(wr), 0);
      chk("rst_din", int'(din), 0);
    end else begin
      chk("ab_same_cycle", int'(a_read), int'(b_read));
      for (int f = 0; f < FLUX; f++) begin
        if (a_read[f]) begin
          if (qa[f].size() == 0) chk("pop_empty_a", 1, 0); else void'(qa[f].pop_front());
          rd_a[f]++;
        end
        if (b_read[f]) begin
          if (qb[f].size() == 0) chk("pop_empty_b", 1, 0); else void'(qb[f].pop_front());
        end
        if (e_read[f]) begin
          if (qe[f].size() == 0) chk("pop_empty_ext", 1, 0); else void'(qe[f].pop_front());
          rd_e[f]++;
        end
        if (r_read[f]) begin
          if (qr[f].size() == 0) chk("pop_empty_real", 1, 0); else void'(qr[f].pop_front());
        end
      end
      if (wr) begin
        t = int'(din[DW]);
        d = int'($signed(din[DW-1:0]));
        wr_cnt++;
        if (t == 1) wr_tag1++;
        if (qx[t].size() == 0) chk("unexpected_write", d, -1);
        else begin
          e = qx[t].pop_front();
          chk("din_data", d, e);
        end
      end
    end
    @(posedge clk);
    #1 refresh();
  endtask

  function automatic bit busy();
    for (int f = 0; f < FLUX; f++)
      if (qa[f].size() || qb[f].size() || qe[f].size() || qx[f].size()) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while (busy() && n < max_cycles) begin
      cycle();
      n++;
    end
    if (busy()) chk("drain_timeout", 1, 0);
  endtask

  task automatic flush();
    for (int f = 0; f < FLUX; f++) begin
      qa[f].delete(); qb[f].delete(); qe[f].delete(); qr[f].delete(); qx[f].delete();
    end
    refresh();
  endtask

  int base_a0, base_a1, base_e1, base_wr, base_t1;

  initial begin
    rst = 1'b1;
    full = 1'b0;
    wr_cnt = 0;
    wr_tag1 = 0;
    for (int f = 0; f < FLUX; f++) begin rd_a[f] = 0; rd_e[f] = 0; end
    refresh();

    // Reset: a ready block must not be touched while rst is high.
    push_block(0, 3, 2, 1, 100);
    repeat (2) cycle();
    rst = 1'b0;

    // Basic block: two dropped pairs, then four sums.
    drain(40);
    chk("basic_writes", wr_cnt, 4);
    chk("basic_pops", rd_a[0], 6);

    // Idle flux must not pull A/B without a size token; then ext=1 consumes silently.
    base_a0 = rd_a[0];
    base_wr = wr_cnt;
    for (int k = 0; k < 4; k++) push_pair(0, 7 + k, 9 + k, 1'b0);
    repeat (3) cycle();
    chk("idle_no_pop", rd_a[0] - base_a0, 0);
    push_size(0, 1, 4);
    drain(20);
    chk("ext1_pops", rd_a[0] - base_a0, 4);
    chk("ext1_writes", wr_cnt - base_wr, 0);

    // Saturation at both rails plus an ordinary negative sum.
    push_size(0, 2, 1); push_pair(0, 0, 0, 1'b0); push_pair(0, 131071, 5, 1'b1);
    push_size(0, 2, 1); push_pair(0, 0, 0, 1'b0); push_pair(0, -131072, -1, 1'b1);
    push_size(0, 2, 1); push_pair(0, 0, 0, 1'b0); push_pair(0, -5, 3, 1'b1);
    drain(30);

    // Backpressure in row 1: row 0 drains, row 1 waits, then resumes intact.
    base_a0 = rd_a[0];
    base_wr = wr_cnt;
    push_block(0, 2, 3, 10, 20);
    full = 1'b1;
    repeat (8) cycle();
    chk("full_row0_pops", rd_a[0] - base_a0, 3);
    chk("full_no_write", wr_cnt - base_wr, 0);
    full = 1'b0;
    drain(20);
    chk("full_total_pops", rd_a[0] - base_a0, 6);
    chk("full_total_writes", wr_cnt - base_wr, 3);

    // Two fluxes: flux 1 starves until flux 0 stalls on full in row 1.
    base_a0 = rd_a[0];
    base_a1 = rd_a[1];
    base_e1 = rd_e[1];
    base_wr = wr_cnt;
    base_t1 = wr_tag1;
    full = 1'b1;
    push_block(0, 2, 2, 1000, 2000);
    push_block(1, 2, 2, 3000, 4000);
    repeat (3) cycle();
    chk("flux1_starved", rd_a[1] - base_a1 + rd_e[1] - base_e1, 0);
    repeat (5) cycle();
    chk("flux0_row0_pops", rd_a[0] - base_a0, 2);
    chk("flux1_load", rd_e[1] - base_e1, 1);
    chk("flux1_row0_pops", rd_a[1] - base_a1, 2);
    chk("flux_full_no_write", wr_cnt - base_wr, 0);
    full = 1'b0;
    drain(20);
    chk("flux_writes", wr_cnt - base_wr, 4);
    chk("flux1_tagged_writes", wr_tag1 - base_t1, 2);

    // Reset mid-block abandons the partial block; a fresh ext=2/real=1 block gives one write.
    push_block(0, 3, 2, 50, 60);
    repeat (4) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    flush();
    base_wr = wr_cnt;
    push_block(0, 2, 1, 7, 8);
    drain(20);
    repeat (2) cycle();
    chk("post_reset_writes", wr_cnt - base_wr, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
